// File: rtl/hw_int_ctrl_pkg.sv
// Shared definitions for the hardware interrupt controller (package mips_defs).
// Holds the line count, the MMIO base and register offsets, and the address
// decoder used by the controller's register window.
package mips_defs;

  localparam int          HWINT_W        = 6;
  localparam logic [31:0] BASE_ADDR_INTC = 32'h0000_7F20;

  localparam logic [31:0] OFF_MODE  = 32'h0;
  localparam logic [31:0] OFF_PEND  = 32'h4;
  localparam logic [31:0] OFF_FORCE = 32'h8;

  typedef enum logic [1:0] {
    REG_MODE  = 2'd0,
    REG_PEND  = 2'd1,
    REG_FORCE = 2'd2,
    REG_NONE  = 2'd3
  } intc_reg_e;

  // Byte offset within the word is ignored; anything outside the three words maps to REG_NONE.
  function automatic intc_reg_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    if (word_addr == base + OFF_MODE)       return REG_MODE;
    else if (word_addr == base + OFF_PEND)  return REG_PEND;
    else if (word_addr == base + OFF_FORCE) return REG_FORCE;
    else                                    return REG_NONE;
  endfunction

endpackage

// File: rtl/hw_int_ctrl_edge_latch.sv
// One interrupt line: previous-sample flop, rise detector and the
// set/clear pending latch. Set (rise or force) wins over clear.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,      // synchronous, active-low
  input  logic samp,       // sampled line level
  input  logic edge_mode,  // 1: edge-latched, 0: level-followed
  input  logic clr,        // write-1-to-clear strobe
  input  logic frc,        // write-1-to-set strobe
  output logic pend        // pending state presented to Cause.IP
);

  logic prev_q, prev_d;
  logic latch_q, latch_d;
  logic rise;

  // Next-state for the edge detector and latch; only edge lines latch on a rise.
  always_comb begin
    prev_d  = samp;
    rise    = samp & ~prev_q;
    latch_d = (latch_q & ~clr) | (edge_mode & rise) | frc;
    pend    = edge_mode ? latch_q : (samp | latch_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      latch_q <= latch_d;
    end
  end

endmodule

// File: rtl/hw_int_ctrl.sv
// Hardware interrupt controller: per-line edge/level capture, pending vector
// to CP0 Cause.IP[7:2], masked request to the pipeline and a 3-word MMIO
// window (MODE, PEND, FORCE).
// Optional feature: define IRQ_SYNC_EN to pass irq_in through a 2-flop
// synchroniser before edge detection (adds 2 cycles of latency).
module hw_int_ctrl
  import mips_defs::*;
#(
  parameter int          HWINT_W   = mips_defs::HWINT_W,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_INTC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [HWINT_W-1:0] irq_in,
  input  logic [HWINT_W-1:0] im,
  input  logic               ie,
  input  logic               exl,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic [HWINT_W-1:0] hwint,
  output logic               int_req
);

  logic [HWINT_W-1:0] samp;
  logic [HWINT_W-1:0] mode_q, mode_d;
  logic [HWINT_W-1:0] clr, frc;
  logic [HWINT_W-1:0] pend_vec;
  intc_reg_e          reg_sel;
  logic               unused_wdata;

  assign unused_wdata = ^wdata[31:HWINT_W];
  assign reg_sel      = decode_reg(addr, BASE_ADDR);

`ifdef IRQ_SYNC_EN
  logic [HWINT_W-1:0] sync1_q, sync1_d;
  logic [HWINT_W-1:0] sync2_q, sync2_d;

  // Two-stage synchroniser input selection.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, cleared by reset so a held line re-detects after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = irq_in;
`endif

  // MMIO write decode: MODE update plus clear/force strobes for the line latches.
  always_comb begin
    mode_d = mode_q;
    clr    = '0;
    frc    = '0;
    if (we) begin
      case (reg_sel)
        REG_MODE:  mode_d = wdata[HWINT_W-1:0];
        REG_PEND:  clr    = wdata[HWINT_W-1:0];
        REG_FORCE: frc    = wdata[HWINT_W-1:0];
        default:   ;
      endcase
    end
  end

  // MODE register.
  always_ff @(posedge clk) begin
    if (!reset) mode_q <= '0;
    else        mode_q <= mode_d;
  end

  for (genvar gi = 0; gi < HWINT_W; gi++) begin : g_line
    irq_edge_latch u_line (
      .clk       (clk),
      .reset     (reset),
      .samp      (samp[gi]),
      .edge_mode (mode_q[gi]),
      .clr       (clr[gi]),
      .frc       (frc[gi]),
      .pend      (pend_vec[gi])
    );
  end

  // Outputs are forced quiet while reset is asserted, since level lines would
  // otherwise follow the raw pins straight through.
  always_comb begin
    hwint   = reset ? pend_vec : '0;
    int_req = (|(hwint & im)) & ie & ~exl;
    rdata   = '0;
    if (reset) begin
      case (reg_sel)
        REG_MODE: rdata[HWINT_W-1:0] = mode_q;
        REG_PEND: rdata[HWINT_W-1:0] = hwint;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_int_ctrl.sv
// Testbench for hw_int_ctrl: directed vector table followed by randomized
// traffic compared against a behavioural reference model.
module tb_hw_int_ctrl;

  localparam logic [31:0] A_MODE  = 32'h7F20;
  localparam logic [31:0] A_PEND  = 32'h7F24;
  localparam logic [31:0] A_FORCE = 32'h7F28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  irq_in, im;
  logic        ie, exl, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [5:0]  hwint;
  logic        int_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hw_int_ctrl dut (
    .clk     (clk),
    .reset   (rst_n),
    .irq_in  (irq_in),
    .im      (im),
    .ie      (ie),
    .exl     (exl),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .hwint   (hwint),
    .int_req (int_req)
  );

  // ---------------- reference model ----------------
  logic [5:0] m_mode  = '0;
  logic [5:0] m_latch = '0;
  logic [5:0] m_prev  = '0;

  function automatic logic [5:0] m_hwint();
    logic [5:0] h;
    h = '0;
    if (rst_n)
      for (int i = 0; i < 6; i++)
        h[i] = m_mode[i] ? m_latch[i] : (irq_in[i] | m_latch[i]);
    return h;
  endfunction

  function automatic logic m_req();
    return ((m_hwint() & im) != 6'd0) && ie && !exl;
  endfunction

  function automatic logic [31:0] m_rdata();
    logic [31:0] wa;
    wa = addr & ~32'd3;
    if (!rst_n)         return 32'd0;
    if (wa == A_MODE)   return {26'd0, m_mode};
    if (wa == A_PEND)   return {26'd0, m_hwint()};
    return 32'd0;
  endfunction

  task automatic model_tick();
    logic [31:0] wa;
    logic [5:0]  new_mode, clr_v, frc_v;
    logic        rise, set_v;
    if (!rst_n) begin
      m_mode = '0; m_latch = '0; m_prev = '0;
    end else begin
      wa = addr & ~32'd3;
      new_mode = m_mode;
      clr_v = '0;
      frc_v = '0;
      if (we && wa == A_MODE)  new_mode = wdata[5:0];
      if (we && wa == A_PEND)  clr_v = wdata[5:0];
      if (we && wa == A_FORCE) frc_v = wdata[5:0];
      for (int i = 0; i < 6; i++) begin
        rise  = irq_in[i] && !m_prev[i];
        set_v = (m_mode[i] && rise) || frc_v[i];
        m_latch[i] = set_v || (m_latch[i] && !clr_v[i]);
      end
      m_prev = irq_in;
      m_mode = new_mode;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model sees the same pre-edge inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst_n;
    logic [5:0]  irq;
    logic [5:0]  im;
    logic        ie;
    logic        exl;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [5:0]  e_hwint;
    logic        e_req;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [5:0] irq, logic [5:0] m, logic e, logic x,
                              logic [31:0] a, logic w, logic [31:0] d,
                              logic [5:0] eh, logic eq, logic [31:0] er);
    vec_t v;
    v.rst_n = r; v.irq = irq; v.im = m; v.ie = e; v.exl = x;
    v.addr = a; v.we = w; v.wdata = d;
    v.e_hwint = eh; v.e_req = eq; v.e_rdata = er;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; irq_in = '0; im = '0; ie = 1'b0; exl = 1'b0;
    addr = '0; we = 1'b0; wdata = '0;

    // reset held with all lines high
    tbl.push_back(mk(0, 6'h3F, 6'h00, 0, 0, 32'h0,   0, 32'h0,        6'h00, 0, 32'h0));
    tbl.push_back(mk(0, 6'h3F, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    // edge latch on line 0
    tbl.push_back(mk(1, 6'h00, 6'h01, 1, 0, A_MODE,  1, 32'h1,        6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h01, 6'h01, 1, 0, A_MODE,  0, 32'h0,        6'h00, 0, 32'h1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 6'h01, 6'h01, 1, 0, A_PEND, 0, 32'h0,       6'h01, 1, 32'h1));
    tbl.push_back(mk(1, 6'h00, 6'h01, 1, 0, A_PEND,  0, 32'h0,        6'h01, 1, 32'h1));
    tbl.push_back(mk(1, 6'h00, 6'h01, 1, 0, A_PEND,  1, 32'h1,        6'h01, 1, 32'h1));
    tbl.push_back(mk(1, 6'h00, 6'h01, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    // level mode on line 2, then masking by exl
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_MODE,  1, 32'h0,        6'h00, 0, 32'h1));
    tbl.push_back(mk(1, 6'h04, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h04, 1, 32'h4));
    tbl.push_back(mk(1, 6'h04, 6'h3F, 1, 1, A_PEND,  0, 32'h0,        6'h04, 0, 32'h4));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    // simultaneous rise and clear, then force
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_MODE,  1, 32'h3F,       6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h02, 6'h3F, 1, 0, A_PEND,  1, 32'h02,       6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_FORCE, 1, 32'h20,       6'h02, 1, 32'h0));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  1, 32'h02,       6'h22, 1, 32'h22));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h20, 1, 32'h20));
    // out-of-window write ignored; sub-word offset still hits PEND
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, 32'h7F2C, 1, 32'h3F,      6'h20, 1, 32'h0));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, 32'h7F26, 1, 32'h20,      6'h20, 1, 32'h20));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    // reset in the middle of a pulse
    tbl.push_back(mk(1, 6'h01, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h01, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h01, 1, 32'h1));
    tbl.push_back(mk(0, 6'h01, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h01, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h01, 1, 32'h1));
    tbl.push_back(mk(1, 6'h01, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h01, 1, 32'h1));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    // MODE upper bits read as zero
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_MODE,  1, 32'hFFFFFFFF, 6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_MODE,  0, 32'h0,        6'h00, 0, 32'h3F));
    // held-high edge line is not re-set after a clear
    tbl.push_back(mk(1, 6'h08, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h08, 6'h3F, 1, 0, A_PEND,  1, 32'h08,       6'h08, 1, 32'h8));
    tbl.push_back(mk(1, 6'h08, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));
    tbl.push_back(mk(1, 6'h00, 6'h3F, 1, 0, A_PEND,  0, 32'h0,        6'h00, 0, 32'h0));

    foreach (tbl[n]) begin
      rst_n = tbl[n].rst_n; irq_in = tbl[n].irq; im = tbl[n].im;
      ie = tbl[n].ie; exl = tbl[n].exl; addr = tbl[n].addr;
      we = tbl[n].we; wdata = tbl[n].wdata;
      #1;
      check($sformatf("vec%0d_hwint", n), {26'd0, hwint}, {26'd0, tbl[n].e_hwint});
      check($sformatf("vec%0d_int_req", n), {31'd0, int_req}, {31'd0, tbl[n].e_req});
      check($sformatf("vec%0d_rdata", n), rdata, tbl[n].e_rdata);
      tick();
    end

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] addrs [7];
      addrs = '{A_MODE, A_PEND, A_FORCE, 32'h7F2C, 32'h7F26, 32'h7F21, 32'h0};
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
      im    = 6'($urandom);
      ie    = ($urandom_range(0, 3) != 0);
      exl   = ($urandom_range(0, 3) == 0);
      we    = ($urandom_range(0, 3) == 0);
      addr  = addrs[$urandom_range(0, 6)];
      wdata = $urandom;
      #1;
      check("rand_hwint", {26'd0, hwint}, {26'd0, m_hwint()});
      check("rand_int_req", {31'd0, int_req}, {31'd0, m_req()});
      check("rand_rdata", rdata, m_rdata());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
